// File: rtl/halloween_pkg.sv
// Shared definitions for the Halloween show sequencer: opcode values,
// opcode class encodings, sequencer state and the decoded-opcode payload.
package halloween_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned ITEM_W = 3;

  // Opcode values: [3:2] = class, [1:0] = item within the class
  localparam logic [OP_W-1:0] ON        = 4'b0000;
  localparam logic [OP_W-1:0] RESET     = 4'b0001;
  localparam logic [OP_W-1:0] GREEN     = 4'b0100;
  localparam logic [OP_W-1:0] PURPLE    = 4'b0101;
  localparam logic [OP_W-1:0] ORANGE    = 4'b0110;
  localparam logic [OP_W-1:0] SCREAMING = 4'b1000;
  localparam logic [OP_W-1:0] CACKLING  = 4'b1001;
  localparam logic [OP_W-1:0] BOO       = 4'b1010;
  localparam logic [OP_W-1:0] WAVEHANDS = 4'b1100;
  localparam logic [OP_W-1:0] MOVEJAW   = 4'b1101;
  localparam logic [OP_W-1:0] FOG       = 4'b1110;

  typedef enum logic [1:0] {
    CLS_SYS   = 2'b00,
    CLS_COLOR = 2'b01,
    CLS_SOUND = 2'b10,
    CLS_MOVE  = 2'b11
  } op_class_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Decoded opcode; item is one-hot (item 0 -> bit 0) and zero when illegal
  typedef struct packed {
    op_class_e         cls;
    logic [ITEM_W-1:0] item;
    logic              is_reset;
    logic              is_illegal;
  } op_dec_t;

endpackage

// File: rtl/halloween_op_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode_i : 4-bit program opcode
//   dec_o    : {class, one-hot item, is_reset, is_illegal}
module halloween_op_decode
  import halloween_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output op_dec_t         dec_o
);

  always_comb begin
    dec_o     = '0;
    dec_o.cls = op_class_e'(opcode_i[3:2]);

    case (opcode_i[1:0])
      2'b00:   dec_o.item = 3'b001;
      2'b01:   dec_o.item = 3'b010;
      2'b10:   dec_o.item = 3'b100;
      default: dec_o.item = '0;
    endcase

    unique case (opcode_i)
      ON:      dec_o.is_reset = 1'b0;
      RESET:   dec_o.is_reset = 1'b1;
      GREEN, PURPLE, ORANGE,
      SCREAMING, CACKLING, BOO,
      WAVEHANDS, MOVEJAW, FOG:
               dec_o.is_illegal = 1'b0;
      default: dec_o.is_illegal = 1'b1;
    endcase

    // Illegal opcodes execute as NOP, so they carry no item
    if (dec_o.is_illegal) begin
      dec_o.item = '0;
    end
  end

endmodule

// File: rtl/halloween_sequencer.sv
// Programmable show sequencer: steps through a table of opcodes under
// start/stop control with a per-step dwell and optional looping, and
// drives held light/movement selects and one-cycle sound strobes.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   prog_we_i/addr_i/data_i  : program table write (dropped while busy)
//   start_i, stop_i          : run control (stop wins over start)
//   loop_en_i                : wrap to slot 0 after the last slot
//   dwell_i                  : extra cycles per step, latched at start
//   busy_o, slot_idx_o       : run status and current slot
//   light_sel_o, move_sel_o  : held one-hot effect selects
//   sound_pulse_o            : one-cycle one-hot sound strobe
//   done_o                   : one-cycle end-of-program pulse
//   op_err_o                 : sticky illegal-opcode flag
module halloween_sequencer
  import halloween_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  parameter int unsigned DWELL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we_i,
  input  logic [SLOT_W-1:0]  prog_addr_i,
  input  logic [OP_W-1:0]    prog_data_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               loop_en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               busy_o,
  output logic [SLOT_W-1:0]  slot_idx_o,
  output logic [ITEM_W-1:0]  light_sel_o,
  output logic [ITEM_W-1:0]  sound_pulse_o,
  output logic [ITEM_W-1:0]  move_sel_o,
  output logic               done_o,
  output logic               op_err_o
);

  seq_state_e         state_q;
  logic [OP_W-1:0]    prog_q [NUM_SLOTS];
  logic [SLOT_W-1:0]  slot_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [ITEM_W-1:0]  light_q;
  logic [ITEM_W-1:0]  sound_q;
  logic [ITEM_W-1:0]  move_q;
  logic               done_q;
  logic               err_q;

  op_dec_t dec;
  logic    running;
  logic    entry;
  logic    step_end;
  logic    last_slot;
  logic    exec_reset;

  halloween_op_decode u_decode (
    .opcode_i (prog_q[slot_q]),
    .dec_o    (dec)
  );

  assign running    = (state_q == RUN);
  // First cycle of a slot: effects for this slot land on the next edge
  assign entry      = running && (cnt_q == '0);
  assign step_end   = (cnt_q == dwell_q);
  assign last_slot  = (slot_q == SLOT_W'(NUM_SLOTS - 1));
  assign exec_reset = entry && dec.is_reset;

  // Program table; writes are ignored while a program runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        prog_q[i] <= '0;
      end
    end else if (prog_we_i && !running && (32'(prog_addr_i) < NUM_SLOTS)) begin
      prog_q[prog_addr_i] <= prog_data_i;
    end
  end

  // Sequencing FSM with registered effect outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      light_q <= '0;
      sound_q <= '0;
      move_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      sound_q <= '0;

      // Effects follow the slot that was current during the previous cycle
      if (entry) begin
        if (dec.cls == CLS_COLOR && !dec.is_illegal) begin
          light_q <= dec.item;
        end else if (dec.is_reset) begin
          light_q <= '0;
        end
        sound_q <= (dec.cls == CLS_SOUND && !dec.is_illegal) ? dec.item : '0;
        move_q  <= (dec.cls == CLS_MOVE  && !dec.is_illegal) ? dec.item : '0;
        if (dec.is_illegal) begin
          err_q <= 1'b1;
        end
      end else if (!running) begin
        move_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= RUN;
            slot_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= dwell_i;
            err_q   <= 1'b0;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_q <= IDLE;
          end else if (exec_reset) begin
            // RESET ends the program at its entry, skipping remaining slots
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (step_end) begin
            cnt_q <= '0;
            if (last_slot) begin
              if (loop_en_i) begin
                slot_q <= '0;
              end else begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
      endcase
    end
  end

  assign busy_o        = running;
  assign slot_idx_o    = slot_q;
  assign light_sel_o   = light_q;
  assign sound_pulse_o = sound_q;
  assign move_sel_o    = move_q;
  assign done_o        = done_q;
  assign op_err_o      = err_q;

endmodule

// File: tb/tb_halloween_sequencer.sv
// Self-checking bench for halloween_sequencer: a directed vector table,
// hand-written corner sequences and a randomized run, all scored against
// a behavioural model of the show program.
module tb_halloween_sequencer;

  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int DW  = 4;

  logic          clk;
  logic          rst;
  logic          prog_we;
  logic [SW-1:0] prog_addr;
  logic [3:0]    prog_data;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [DW-1:0] dwell;
  logic          busy;
  logic [SW-1:0] slot_idx;
  logic [2:0]    light_sel;
  logic [2:0]    sound_pulse;
  logic [2:0]    move_sel;
  logic          done;
  logic          op_err;

  int    checks;
  int    failures;
  string phase;

  halloween_sequencer #(
    .NUM_SLOTS (NS),
    .SLOT_W    (SW),
    .DWELL_W   (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .prog_we_i     (prog_we),
    .prog_addr_i   (prog_addr),
    .prog_data_i   (prog_data),
    .start_i       (start),
    .stop_i        (stop),
    .loop_en_i     (loop_en),
    .dwell_i       (dwell),
    .busy_o        (busy),
    .slot_idx_o    (slot_idx),
    .light_sel_o   (light_sel),
    .sound_pulse_o (sound_pulse),
    .move_sel_o    (move_sel),
    .done_o        (done),
    .op_err_o      (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0] m_tab [NS];
  bit         m_run;
  int         m_slot;
  int         m_age;
  int         m_dwell;
  logic [2:0] m_light, m_sound, m_move;
  bit         m_done, m_err;

  function automatic bit op_legal(input logic [3:0] op);
    int lo;
    lo = int'(op) % 4;
    return !(op == 4'b0010 || lo == 3);
  endfunction

  function automatic logic [2:0] op_item(input logic [3:0] op);
    int lo;
    lo = int'(op) % 4;
    return (lo == 0) ? 3'b001 : (lo == 1) ? 3'b010 : (lo == 2) ? 3'b100 : 3'b000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_tab[i] = 4'b0000;
    m_run = 0; m_slot = 0; m_age = 0; m_dwell = 0;
    m_light = '0; m_sound = '0; m_move = '0; m_done = 0; m_err = 0;
  endtask

  // One clock edge of the show: effects of the slot seen last cycle,
  // then the step/slot bookkeeping.
  task automatic model_edge();
    logic [3:0] op;
    bit         first;
    bit         lg;
    int         cls;
    logic [2:0] item;
    if (rst) begin
      model_reset();
      return;
    end
    op    = m_tab[m_slot];
    first = m_run && (m_age == 0);
    lg    = op_legal(op);
    cls   = int'(op) / 4;
    item  = op_item(op);
    m_sound = '0;
    m_done  = 0;
    if (first) begin
      if (cls == 1 && lg) m_light = item;
      if (op == 4'b0001) m_light = '0;
      m_sound = (cls == 2 && lg) ? item : 3'b000;
      m_move  = (cls == 3 && lg) ? item : 3'b000;
      if (!lg) m_err = 1;
    end else if (!m_run) begin
      m_move = '0;
    end
    if (!m_run) begin
      if (prog_we) m_tab[int'(prog_addr)] = prog_data;
      if (start && !stop) begin
        m_run = 1; m_slot = 0; m_age = 0; m_dwell = int'(dwell); m_err = 0;
      end
    end else if (stop) begin
      m_run = 0;
    end else if (first && op == 4'b0001) begin
      m_run = 0; m_done = 1;
    end else if (m_age + 1 == m_dwell + 1) begin
      m_age = 0;
      if (m_slot == NS - 1) begin
        if (loop_en) m_slot = 0;
        else begin m_run = 0; m_done = 1; end
      end else begin
        m_slot = m_slot + 1;
      end
    end else begin
      m_age = m_age + 1;
    end
  endtask

  task automatic check_model();
    logic [13:0] act, exp;
    act = {busy, slot_idx, light_sel, sound_pulse, move_sel, done, op_err};
    exp = {m_run, SW'(m_slot), m_light, m_sound, m_move, m_done, m_err};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model_%s t=%0t dut=%b expected=%b", phase, $time, act, exp);
    end
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic write_prog(input logic [3:0] a, b, c, d);
    logic [3:0] ops [NS];
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = d;
    for (int i = 0; i < NS; i++) begin
      prog_we = 1'b1; prog_addr = SW'(i); prog_data = ops[i];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic do_start(input int dw);
    dwell = DW'(dw); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       start, stop, loop_en;
    logic       busy;
    logic [1:0] slot;
    logic [2:0] light, sound, move;
    logic       done;
  } vec_t;

  vec_t vt [6];

  initial begin
    int n_move, n_sound, n_done, n_slot1, n_fx, light_at_done, saw_orange;
    checks = 0; failures = 0; phase = "reset";
    rst = 1'b1; prog_we = 0; prog_addr = '0; prog_data = '0;
    start = 0; stop = 0; loop_en = 0; dwell = '0;
    model_reset();
    tick(); tick();
    expect_eq("reset_outputs", int'({busy, slot_idx, light_sel, sound_pulse, move_sel, done, op_err}), 0);
    rst = 1'b0;
    tick();

    // Program 0101,1001,1101,0000, dwell 0, no loop
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'b010, 3'b000, 3'b000, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b010, 3'b010, 3'b000, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'b010, 3'b000, 3'b010, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'b010, 3'b000, 3'b000, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'b010, 3'b000, 3'b000, 1'b0};

    phase = "table";
    write_prog(4'b0101, 4'b1001, 4'b1101, 4'b0000);
    dwell = '0;
    for (int i = 0; i < 6; i++) begin
      start = vt[i].start; stop = vt[i].stop; loop_en = vt[i].loop_en;
      tick();
      expect_eq($sformatf("table_vec%0d", i),
                int'({busy, slot_idx, light_sel, sound_pulse, move_sel, done}),
                int'({vt[i].busy, vt[i].slot, vt[i].light, vt[i].sound, vt[i].move, vt[i].done}));
    end
    start = 0;

    // Same program with dwell 2
    phase = "dwell2";
    do_start(2);
    n_move = 0; n_sound = 0; n_done = 0; n_slot1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (move_sel == 3'b010) n_move++;
      if (sound_pulse != 3'b000) n_sound++;
      if (done) n_done++;
      if (busy && slot_idx == 2'd1) n_slot1++;
    end
    expect_eq("dwell2_move_cycles", n_move, 3);
    expect_eq("dwell2_sound_cycles", n_sound, 1);
    expect_eq("dwell2_slot1_cycles", n_slot1, 3);
    expect_eq("dwell2_done_count", n_done, 1);

    // RESET opcode ends the program at its entry
    phase = "resetop";
    write_prog(4'b0110, 4'b0001, 4'b1000, 4'b1000);
    do_start(0);
    n_sound = 0; n_done = 0; light_at_done = -1; saw_orange = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sound_pulse != 3'b000) n_sound++;
      if (light_sel == 3'b100) saw_orange = 1;
      if (done) begin n_done++; light_at_done = int'(light_sel); end
    end
    expect_eq("resetop_orange_seen", saw_orange, 1);
    expect_eq("resetop_light_at_done", light_at_done, 0);
    expect_eq("resetop_sound_count", n_sound, 0);
    expect_eq("resetop_done_count", n_done, 1);

    // Looping: a sound every 4 cycles, then loop off, then stop mid-run
    phase = "loop";
    write_prog(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    loop_en = 1'b1;
    do_start(0);
    n_sound = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (sound_pulse == 3'b001) n_sound++;
    end
    expect_eq("loop_sound_pulses", n_sound, 4);
    loop_en = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    expect_eq("loop_off_done", n_done, 1);
    expect_eq("loop_off_idle", int'(busy), 0);

    phase = "stop";
    loop_en = 1'b1;
    do_start(0);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    expect_eq("stop_busy", int'(busy), 0);
    n_done = int'(done);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) n_done++;
    end
    expect_eq("stop_no_done", n_done, 0);
    expect_eq("stop_effects_clear", int'({sound_pulse, move_sel}), 0);
    loop_en = 1'b0;

    // Illegal opcode sets a sticky error cleared by the next start
    phase = "operr";
    write_prog(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    do_start(0);
    repeat (6) tick();
    expect_eq("operr_set", int'(op_err), 1);
    repeat (3) tick();
    expect_eq("operr_sticky", int'(op_err), 1);
    do_start(0);
    expect_eq("operr_cleared", int'(op_err), 0);
    repeat (6) tick();

    // Writes while busy are dropped
    phase = "busywr";
    write_prog(4'b0101, 4'b0000, 4'b0000, 4'b0000);
    do_start(3);
    prog_we = 1'b1; prog_addr = 2'd0; prog_data = 4'b1000;
    tick(); tick();
    prog_we = 1'b0;
    repeat (20) tick();
    do_start(0);
    n_sound = 0; n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sound_pulse != 3'b000) n_sound++;
      if (done) n_done++;
    end
    expect_eq("busywr_sound_count", n_sound, 0);
    expect_eq("busywr_done_count", n_done, 1);
    expect_eq("busywr_light", int'(light_sel), 2);

    // Asynchronous reset mid-program, then an all-NOP run
    phase = "rstmid";
    write_prog(4'b0101, 4'b1001, 4'b1101, 4'b0000);
    do_start(3);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    expect_eq("rstmid_outputs", int'({busy, slot_idx, light_sel, sound_pulse, move_sel, done, op_err}), 0);
    model_reset();
    tick();
    rst = 1'b0;
    do_start(0);
    n_fx = 0; n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({light_sel, sound_pulse, move_sel} != 9'd0) n_fx++;
      if (done) n_done++;
    end
    expect_eq("rstmid_nop_effects", n_fx, 0);
    expect_eq("rstmid_done_count", n_done, 1);

    // Randomized traffic against the model
    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      prog_we   = ($urandom % 4) == 0;
      prog_addr = SW'($urandom);
      prog_data = 4'($urandom);
      start     = ($urandom % 10) == 0;
      stop      = ($urandom % 25) == 0;
      if (($urandom % 16) == 0) loop_en = ~loop_en;
      dwell     = DW'($urandom % 4);
      rst       = ($urandom % 400) == 0;
      tick();
    end
    rst = 0; prog_we = 0; start = 0; stop = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
